// File: rtl/mmio_uart_tx_if.sv
// Core load/store data-port bundle shared by data memory and the UART transmitter.
interface mmio_uart_tx_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] m_addr;
  logic [31:0] m_wr_dat;
  logic [31:0] m_rd_dat;

  modport master (output rd_en, output wr_en, output m_addr, output m_wr_dat, input m_rd_dat);
  modport slave  (input rd_en, input wr_en, input m_addr, input m_wr_dat, output m_rd_dat);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a small FIFO, a bit-timed
// FSM serialises it on tx. Read data is zero unless selected so it can be ORed onto the bus.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [BAUD_W-1:0] baud_r, baud_nxt_s;
  logic [2:0]        bit_r, bit_nxt_s;
  logic [7:0]        shift_r, shift_nxt_s;
  logic              tx_r, tx_nxt_s;
  logic              busy_r, busy_nxt_s;

  logic [7:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic             ovf_r;

  logic        hit_s, wr_txdata_s, wr_status_s, full_s, empty_s, push_s, pop_s;
  logic [1:0]  sel_s;
  logic [31:0] rd_dat_s;
  logic        unused_s;

  function automatic logic [31:0] pack_status(input logic [CNT_W-1:0] cnt, input logic ovf,
                                              input logic empty, input logic full,
                                              input logic bsy);
    return {16'h0000, 8'(cnt), 4'h0, ovf, empty, full, bsy};
  endfunction

  assign hit_s       = (bus.m_addr[31:4] == BASE_ADDR[31:4]);
  assign sel_s       = bus.m_addr[3:2];
  assign wr_txdata_s = bus.wr_en & hit_s & (sel_s == 2'd0);
  assign wr_status_s = bus.wr_en & hit_s & (sel_s == 2'd1);
  assign full_s      = (count_r == CNT_FULL);
  assign empty_s     = (count_r == {CNT_W{1'b0}});
  assign push_s      = wr_txdata_s & ~full_s;
  assign unused_s    = ^{bus.m_addr[1:0], bus.m_wr_dat[31:8]};

  // Serialiser next state; a frame end with data waiting goes straight to START.
  always_comb begin
    state_nxt_s = state_r;
    baud_nxt_s  = baud_r;
    bit_nxt_s   = bit_r;
    shift_nxt_s = shift_r;
    pop_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          shift_nxt_s = mem_r[rd_ptr_r];
          bit_nxt_s   = 3'd0;
          baud_nxt_s  = BAUD_RELOAD;
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_r == {BAUD_W{1'b0}}) begin
          baud_nxt_s  = BAUD_RELOAD;
          state_nxt_s = ST_DATA;
        end else begin
          baud_nxt_s = baud_r - BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_r == {BAUD_W{1'b0}}) begin
          baud_nxt_s  = BAUD_RELOAD;
          shift_nxt_s = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
            state_nxt_s = ST_STOP;
          end else begin
            bit_nxt_s = bit_r + 3'd1;
          end
        end else begin
          baud_nxt_s = baud_r - BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_r == {BAUD_W{1'b0}}) begin
          if (!empty_s) begin
            pop_s       = 1'b1;
            shift_nxt_s = mem_r[rd_ptr_r];
            bit_nxt_s   = 3'd0;
            baud_nxt_s  = BAUD_RELOAD;
            state_nxt_s = ST_START;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          baud_nxt_s = baud_r - BAUD_W'(1);
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so tx and busy can be registered.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
    case (state_nxt_s)
      ST_START: tx_nxt_s = 1'b0;
      ST_DATA:  tx_nxt_s = shift_nxt_s[0];
      default:  tx_nxt_s = 1'b1;
    endcase
    busy_nxt_s = (count_nxt_s != {CNT_W{1'b0}}) || (state_nxt_s != ST_IDLE);
  end

  // Serialiser state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      baud_r  <= {BAUD_W{1'b0}};
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      baud_r  <= baud_nxt_s;
      bit_r   <= bit_nxt_s;
      shift_r <= shift_nxt_s;
      tx_r    <= tx_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  // FIFO bookkeeping and sticky overflow; a set beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      ovf_r    <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_nxt_s;
      if (wr_txdata_s && full_s) begin
        ovf_r <= 1'b1;
      end else if (wr_status_s && bus.m_wr_dat[3]) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= bus.m_wr_dat[7:0];
  end

  // Read mux: only STATUS carries data, everything else reads as zero.
  always_comb begin
    rd_dat_s = 32'h0000_0000;
    if (bus.rd_en && hit_s) begin
      case (sel_s)
        2'd1:    rd_dat_s = pack_status(count_r, ovf_r, empty_s, full_s, busy_r);
        default: rd_dat_s = 32'h0000_0000;
      endcase
    end else begin
      rd_dat_s = 32'h0000_0000;
    end
  end

  assign bus.m_rd_dat = rd_dat_s;
  assign tx           = tx_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a frame-timeline/queue model checked every cycle, plus
// literal expectations for the directed scenarios, then a randomized bus phase.
module tb_mmio_uart_tx;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx, busy;
  mmio_uart_tx_if bus_if ();

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus_if), .tx(tx), .busy(busy));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  // Reference model: queued bytes plus the cycle index inside the current frame.
  logic [7:0] q[$];
  logic       m_active = 1'b0;
  int         m_k = 0;
  logic [7:0] m_byte = 8'h00;
  logic       m_ovf = 1'b0;
  logic       m_busy = 1'b0;
  logic       m_tx = 1'b1;
  int         sz;
  logic       hit, w_data, w_stat, do_pop;

  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    else if (j <= 8) return b[j-1];
    else return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_active = 1'b0;
      m_k = 0;
      m_ovf = 1'b0;
      m_busy = 1'b0;
    end else begin
      sz = q.size();
      hit = (bus_if.m_addr[31:4] == BASE[31:4]);
      w_data = bus_if.wr_en && hit && (bus_if.m_addr[3:2] == 2'd0);
      w_stat = bus_if.wr_en && hit && (bus_if.m_addr[3:2] == 2'd1);
      do_pop = 1'b0;
      if (!m_active) begin
        if (sz > 0) do_pop = 1'b1;
      end else if (m_k == 10 * CPB - 1) begin
        m_active = 1'b0;
        if (sz > 0) do_pop = 1'b1;
      end else begin
        m_k = m_k + 1;
      end
      if (do_pop) begin
        m_byte = q.pop_front();
        m_active = 1'b1;
        m_k = 0;
      end
      if (w_stat && bus_if.m_wr_dat[3]) m_ovf = 1'b0;
      if (w_data) begin
        if (sz == DEPTH) m_ovf = 1'b1;
        else q.push_back(bus_if.m_wr_dat[7:0]);
      end
      m_busy = m_active || (q.size() > 0);
    end
    m_tx = m_active ? frame_bit(m_byte, m_k / CPB) : 1'b1;
  end

  function automatic logic [31:0] model_rd();
    logic [31:0] v;
    v = 32'h0;
    if (bus_if.rd_en && (bus_if.m_addr[31:4] == BASE[31:4]) && (bus_if.m_addr[3:2] == 2'd1))
      v = {16'h0, 8'(q.size()), 4'h0, m_ovf, q.size() == 0, q.size() == DEPTH, m_busy};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: compare against the model at the falling edge, then step past the rising edge.
  task automatic cyc();
    @(negedge clk);
    if (chk_en) begin
      chk("model_tx", {31'h0, tx}, {31'h0, m_tx});
      chk("model_busy", {31'h0, busy}, {31'h0, m_busy});
      chk("model_rd_dat", bus_if.m_rd_dat, model_rd());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus_if.rd_en = r;
    bus_if.wr_en = w;
    bus_if.m_addr = a;
    bus_if.m_wr_dat = d;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    drive(1'b0, 1'b1, a, d);
    cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic read_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    drive(1'b1, 1'b0, a, 32'h0);
    #1;
    chk(nm, bus_if.m_rd_dat, exp);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    while (busy !== 1'b0 && n < 1000) begin
      cyc();
      n++;
    end
    chk("drain", {31'h0, busy}, 32'h0);
    cyc();
  endtask

  logic [9:0] exp_frame;
  int n, lows;

  initial begin
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    chk_en = 1'b1;
    cyc();
    reset = 1'b0;

    // 1: reset state
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    read_chk("rst_status", 32'h0000_1004, 32'h0000_0004);
    cyc();

    // 2: single 0xA5 frame, bit by bit
    store(32'h0000_1000, 32'h0000_00A5);
    chk("busy_rise", {31'h0, busy}, 32'h1);
    exp_frame = 10'b11_0100_1010;
    for (int k = 0; k < 40; k++) begin
      cyc();
      chk("a5_tx", {31'h0, tx}, {31'h0, exp_frame[k/4]});
      chk("a5_busy", {31'h0, busy}, 32'h1);
    end
    cyc();
    chk("a5_busy_fall", {31'h0, busy}, 32'h0);
    wait_idle();

    // 3: overflow and back-to-back frames
    for (int i = 0; i < 6; i++) store(32'h0000_1000, 32'h10 + i);
    read_chk("ovf_status", 32'h0000_1004, 32'h0000_040B);
    drive(1'b1, 1'b1, 32'h0000_1004, 32'h0000_0008);
    cyc();
    read_chk("ovf_cleared", 32'h0000_1004, 32'h0000_0403);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      cyc();
      n++;
    end
    chk("b2b_len", n, 32'd195);
    wait_idle();

    // 4: reset during data bit 3
    store(32'h0000_1000, 32'h0000_003C);
    repeat (17) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst_mid_tx", {31'h0, tx}, 32'h1);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    read_chk("rst_mid_status", 32'h0000_1004, 32'h0000_0004);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      cyc();
      if (tx !== 1'b1) lows++;
    end
    chk("rst_no_frame", lows, 32'd0);

    // 5: non-status and out-of-window accesses
    read_chk("rd_txdata", 32'h0000_1000, 32'h0);
    read_chk("rd_res8", 32'h0000_1008, 32'h0);
    read_chk("rd_resC", 32'h0000_100C, 32'h0);
    read_chk("rd_miss", 32'h0000_2004, 32'h0);
    cyc();
    store(32'h0000_2000, 32'h0000_0055);
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    chk("miss_quiet", lows, 32'd0);

    // 6: full FIFO, pop and dropped push in the same cycle
    for (int i = 0; i < 5; i++) store(32'h0000_1000, 32'h21 + i);
    repeat (35) cyc();
    read_chk("full_status", 32'h0000_1004, 32'h0000_0403);
    cyc();
    drive(1'b0, 1'b1, 32'h0000_1000, 32'h0000_0099);
    cyc();
    read_chk("pop_drop_status", 32'h0000_1004, 32'h0000_0309);
    wait_idle();

    // randomized bus traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 5))
        0, 1:    a = 32'h0000_1000;
        2:       a = 32'h0000_1004;
        3:       a = 32'h0000_1008;
        4:       a = 32'h0000_100C;
        default: a = 32'h0000_2000;
      endcase
      a[1:0] = 2'($urandom_range(0, 3));
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 30), a, $urandom);
      reset = ($urandom_range(0, 499) == 0);
      cyc();
    end
    reset = 1'b0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
